// File: rtl/dlsc_cpu1_alu_seq_pkg.sv
// Shared ALU encodings (mode, add/compare op, logic op, shift direction) and FSM state encoding
// for dlsc_cpu1_alu_seq, its decoder and its bench.
package dlsc_cpu1_alu_seq_pkg;

    localparam logic [1:0] ALU_MODE_ADD    = 2'b00;
    localparam logic [1:0] ALU_MODE_COMP   = 2'b01;
    localparam logic [1:0] ALU_MODE_SHIFT  = 2'b10;
    localparam logic [1:0] ALU_MODE_LOGIC  = 2'b11;

    localparam logic [1:0] ALU_ADD_ADD     = 2'b00;
    localparam logic [1:0] ALU_ADD_SUB     = 2'b01;
    localparam logic [1:0] ALU_ADD_EQU     = 2'b10;
    localparam logic [1:0] ALU_ADD_NEQU    = 2'b11;

    localparam logic [1:0] ALU_LOGIC_AND   = 2'b00;
    localparam logic [1:0] ALU_LOGIC_OR    = 2'b01;
    localparam logic [1:0] ALU_LOGIC_XOR   = 2'b10;
    localparam logic [1:0] ALU_LOGIC_NOR   = 2'b11;

    localparam logic       ALU_SHIFT_LEFT  = 1'b0;
    localparam logic       ALU_SHIFT_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } alu_state_e;

endpackage

// File: rtl/dlsc_cpu1_alu_shift_step.sv
// Combinational single-step shifter on the DATA+1-bit sign-extended operand:
// left shifts zero-fill, right shifts replicate the extension bit.
module dlsc_cpu1_alu_shift_step
    import dlsc_cpu1_alu_seq_pkg::*;
#(
    parameter int DATA       = 32,
    parameter int SHIFT_STEP = 8
) (
    input  logic signed [DATA:0]                     din,
    input  logic        [$clog2(SHIFT_STEP):0]       amt,
    input  logic                                     dir,
    output logic signed [DATA:0]                     dout
);

    always_comb begin
        dout = din;
        case (dir)
            ALU_SHIFT_LEFT:  dout = din << amt;
            ALU_SHIFT_RIGHT: dout = din >>> amt;
        endcase
    end

endmodule

// File: rtl/dlsc_cpu1_alu_seq.sv
// Registered, handshaked cpu1 ALU with iterative shifter (SHIFT_STEP bits/cycle).
// Optional shift-add multiplier built only when DLSC_CPU1_ALU_MUL_EN is defined.
module dlsc_cpu1_alu_seq
    import dlsc_cpu1_alu_seq_pkg::*;
#(
    parameter int DATA       = 32,
    parameter int SHIFT_STEP = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [1:0]      in_add_op,
    input  logic [1:0]      in_logic_op,
    input  logic            in_logic_bypass,
    input  logic            in_shift_op,
    input  logic            in_mul,
    input  logic [DATA-1:0] in_a,
    input  logic [DATA-1:0] in_b,
    input  logic            in_a_sign,
    input  logic            in_b_sign,
    input  logic [DATA-1:0] in_bypass,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_d,
    output logic            out_flag,
    output logic            out_overflow
);

    localparam int SHW = $clog2(DATA);
    localparam int SSW = $clog2(SHIFT_STEP) + 1;
    localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

    alu_state_e             state_q, state_d;
    logic                   vld_q, vld_d;
    logic [DATA-1:0]        res_q, res_d;
    logic                   flag_q, flag_d;
    logic                   ovf_q, ovf_d;
    logic signed [DATA:0]   work_q, work_d;
    logic [SHW-1:0]         rem_q, rem_d;
    logic                   dir_q, dir_d;

    logic                   accept;
    logic signed [DATA:0]   a_ext, b_ext, sum_ext;
    logic                   is_cmp, flag_arith;
    logic [DATA-1:0]        res_c;
    logic                   flag_c, ovf_c;
    logic [SHW-1:0]         step_n;
    logic signed [DATA:0]   work_sh;

`ifdef DLSC_CPU1_ALU_MUL_EN
    logic [2*DATA-1:0]      prod_q, prod_d, prod_nx;
    logic [DATA-1:0]        mcand_q, mcand_d;
    logic [DATA:0]          psum;
`else
    logic                   unused_in_mul;
    assign unused_in_mul = in_mul;
`endif

    assign in_ready  = (state_q == ST_IDLE) && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_q;
    assign out_d     = res_q;
    assign out_flag  = flag_q;
    assign out_overflow = ovf_q;

    // Single-cycle result for ADD/COMP/LOGIC (and zero-amount SHIFT)
    always_comb begin
        a_ext = {in_a_sign, in_a};
        b_ext = {in_b_sign, in_b};
        case (in_add_op)
            ALU_ADD_ADD: sum_ext = a_ext + b_ext;
            ALU_ADD_SUB: sum_ext = a_ext - b_ext;
            default:     sum_ext = a_ext - b_ext;
        endcase
        is_cmp     = (in_add_op == ALU_ADD_EQU) || (in_add_op == ALU_ADD_NEQU);
        flag_arith = is_cmp ? ((a_ext == b_ext) ^ (in_add_op == ALU_ADD_NEQU)) : sum_ext[DATA];
        res_c  = in_a;
        flag_c = 1'b0;
        ovf_c  = 1'b0;
        case (in_mode)
            ALU_MODE_ADD: begin
                res_c  = is_cmp ? '0 : sum_ext[DATA-1:0];
                flag_c = flag_arith;
                ovf_c  = is_cmp ? 1'b0 : (sum_ext[DATA] ^ sum_ext[DATA-1]);
            end
            ALU_MODE_COMP: begin
                res_c  = {{(DATA-1){1'b0}}, flag_arith};
                flag_c = flag_arith;
            end
            ALU_MODE_SHIFT: res_c = in_a;
            ALU_MODE_LOGIC: begin
                if (in_logic_bypass) begin
                    res_c = in_bypass;
                end else begin
                    case (in_logic_op)
                        ALU_LOGIC_AND: res_c = in_a & in_b;
                        ALU_LOGIC_OR:  res_c = in_a | in_b;
                        ALU_LOGIC_XOR: res_c = in_a ^ in_b;
                        ALU_LOGIC_NOR: res_c = ~(in_a | in_b);
                    endcase
                end
            end
        endcase
    end

    // Step never exceeds the remaining amount, so it always fits SHW bits
    assign step_n = ({1'b0, rem_q} > STEP_W) ? STEP_W[SHW-1:0] : rem_q;

    dlsc_cpu1_alu_shift_step #(
        .DATA       (DATA),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .din  (work_q),
        .amt  (SSW'(step_n)),
        .dir  (dir_q),
        .dout (work_sh)
    );

`ifdef DLSC_CPU1_ALU_MUL_EN
    always_comb begin
        psum    = {1'b0, prod_q[2*DATA-1:DATA]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nx = {psum, prod_q[DATA-1:1]};
    end
`endif

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q && !out_ready;
        res_d   = res_q;
        flag_d  = flag_q;
        ovf_d   = ovf_q;
        work_d  = work_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
`ifdef DLSC_CPU1_ALU_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef DLSC_CPU1_ALU_MUL_EN
                    if (in_mul) begin
                        prod_d  = {{DATA{1'b0}}, in_b};
                        mcand_d = in_a;
                        rem_d   = '1;
                        state_d = ST_MUL;
                    end else
`endif
                    if (in_mode == ALU_MODE_SHIFT && in_b[SHW-1:0] != '0) begin
                        work_d  = a_ext;
                        rem_d   = in_b[SHW-1:0];
                        dir_d   = in_shift_op;
                        state_d = ST_SHIFT;
                    end else begin
                        res_d   = res_c;
                        flag_d  = flag_c;
                        ovf_d   = ovf_c;
                        vld_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = work_sh;
                rem_d  = rem_q - step_n;
                if (rem_q == step_n) begin
                    res_d   = work_sh[DATA-1:0];
                    flag_d  = 1'b0;
                    ovf_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`ifdef DLSC_CPU1_ALU_MUL_EN
            ST_MUL: begin
                prod_d = prod_nx;
                rem_d  = rem_q - 1'b1;
                if (rem_q == '0) begin
                    res_d   = prod_nx[DATA-1:0];
                    flag_d  = 1'b0;
                    ovf_d   = |prod_nx[2*DATA-1:DATA];
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
        end
    end

    // Iteration working state needs no reset: it is reloaded on every accept
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        rem_q   <= rem_d;
        dir_q   <= dir_d;
`ifdef DLSC_CPU1_ALU_MUL_EN
        prod_q  <= prod_d;
        mcand_q <= mcand_d;
`endif
    end

endmodule

// File: tb/tb_dlsc_cpu1_alu_seq.sv
// Bench for dlsc_cpu1_alu_seq (DATA=32, SHIFT_STEP=8): vector table plus multi-cycle sequences;
// multiply sequences are included when DLSC_CPU1_ALU_MUL_EN is defined.
module tb_dlsc_cpu1_alu_seq;
    import dlsc_cpu1_alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_mode, in_add_op, in_logic_op;
    logic        in_logic_bypass, in_shift_op, in_mul;
    logic [31:0] in_a, in_b, in_bypass;
    logic        in_a_sign, in_b_sign;
    logic        out_valid, out_ready;
    logic [31:0] out_d;
    logic        out_flag, out_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dlsc_cpu1_alu_seq #(.DATA(32), .SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_add_op(in_add_op), .in_logic_op(in_logic_op),
        .in_logic_bypass(in_logic_bypass), .in_shift_op(in_shift_op), .in_mul(in_mul),
        .in_a(in_a), .in_b(in_b), .in_a_sign(in_a_sign), .in_b_sign(in_b_sign),
        .in_bypass(in_bypass), .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_flag(out_flag), .out_overflow(out_overflow)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  aop;
        logic [1:0]  lop;
        logic        byp_en;
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        bs;
        logic [31:0] byp;
        logic [31:0] ed;
        logic        ef;
        logic        eo;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic [1:0] aop, input logic [1:0] lop,
                         input logic byp_en, input logic sop, input logic mul,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic bs, input logic [31:0] byp);
        in_mode = mode; in_add_op = aop; in_logic_op = lop; in_logic_bypass = byp_en;
        in_shift_op = sop; in_mul = mul; in_a = a; in_b = b; in_a_sign = as; in_b_sign = bs;
        in_bypass = byp; in_valid = 1'b1;
    endtask

    // Issue one op, count edges (accept edge = 1) until out_valid; check latency and result
    task automatic run_multi(input string nm, input logic mode_shift_dir, input logic mul,
                             input logic [31:0] a, input logic as, input logic [31:0] b,
                             input logic [31:0] exp_d, input logic exp_o, input int exp_lat);
        int lat;
        @(negedge clk);
        drive(ALU_MODE_SHIFT, ALU_ADD_ADD, ALU_LOGIC_AND, 1'b0, mode_shift_dir, mul, a, b, as, 1'b0, 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && exp_lat > 1) chk({nm, "_busy_ready"}, {31'b0, in_ready}, 32'd0);
            if (out_valid) break;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_d"}, out_d, exp_d);
        chk({nm, "_flag"}, {31'b0, out_flag}, 32'd0);
        chk({nm, "_ovf"}, {31'b0, out_overflow}, {31'b0, exp_o});
    endtask

    initial begin
        vecs[0]  = '{ALU_MODE_ADD,   ALU_ADD_ADD,  ALU_LOGIC_AND, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 0, 1};
        vecs[1]  = '{ALU_MODE_ADD,   ALU_ADD_SUB,  ALU_LOGIC_AND, 0, 0, 32'd5, 32'd7, 0, 0, 0, 32'hFFFFFFFE, 1, 0};
        vecs[2]  = '{ALU_MODE_COMP,  ALU_ADD_EQU,  ALU_LOGIC_AND, 0, 0, 32'h1234, 32'h1234, 0, 0, 0, 32'h1, 1, 0};
        vecs[3]  = '{ALU_MODE_COMP,  ALU_ADD_NEQU, ALU_LOGIC_AND, 0, 0, 32'h1234, 32'h1234, 0, 0, 0, 32'h0, 0, 0};
        vecs[4]  = '{ALU_MODE_ADD,   ALU_ADD_EQU,  ALU_LOGIC_AND, 0, 0, 32'd5, 32'd5, 0, 0, 0, 32'h0, 1, 0};
        vecs[5]  = '{ALU_MODE_ADD,   ALU_ADD_ADD,  ALU_LOGIC_AND, 0, 0, 32'hFFFFFFFF, 32'h1, 1, 0, 0, 32'h0, 0, 0};
        vecs[6]  = '{ALU_MODE_ADD,   ALU_ADD_ADD,  ALU_LOGIC_AND, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 1, 1};
        vecs[7]  = '{ALU_MODE_COMP,  ALU_ADD_SUB,  ALU_LOGIC_AND, 0, 0, 32'd3, 32'd9, 0, 0, 0, 32'h1, 1, 0};
        vecs[8]  = '{ALU_MODE_LOGIC, ALU_ADD_ADD,  ALU_LOGIC_AND, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'hF000F000, 0, 0};
        vecs[9]  = '{ALU_MODE_LOGIC, ALU_ADD_ADD,  ALU_LOGIC_OR,  0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'hFFF0FFF0, 0, 0};
        vecs[10] = '{ALU_MODE_LOGIC, ALU_ADD_ADD,  ALU_LOGIC_XOR, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'h0FF00FF0, 0, 0};
        vecs[11] = '{ALU_MODE_LOGIC, ALU_ADD_ADD,  ALU_LOGIC_NOR, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'h000F000F, 0, 0};
        vecs[12] = '{ALU_MODE_LOGIC, ALU_ADD_ADD,  ALU_LOGIC_AND, 1, 0, 32'h1, 32'h2, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        vecs[13] = '{ALU_MODE_SHIFT, ALU_ADD_ADD,  ALU_LOGIC_AND, 0, ALU_SHIFT_LEFT, 32'h12345678, 32'h0, 0, 0, 0, 32'h12345678, 0, 0};
        vecs[14] = '{ALU_MODE_SHIFT, ALU_ADD_ADD,  ALU_LOGIC_AND, 0, ALU_SHIFT_RIGHT, 32'h80000000, 32'h20, 1, 0, 0, 32'h80000000, 0, 0};
        vecs[15] = '{ALU_MODE_COMP,  ALU_ADD_EQU,  ALU_LOGIC_AND, 0, 0, 32'd5, 32'd5, 1, 0, 0, 32'h0, 0, 0};

        rst = 1'b1; out_ready = 1'b1;
        drive(ALU_MODE_ADD, ALU_ADD_ADD, ALU_LOGIC_AND, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_d", out_d, 32'd0);
        chk("rst_flag", {31'b0, out_flag}, 32'd0);
        chk("rst_ovf", {31'b0, out_overflow}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].aop, vecs[i].lop, vecs[i].byp_en, vecs[i].sop, 1'b0,
                  vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].byp);
            @(posedge clk);
            #1 in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_d", i), out_d, vecs[i].ed);
            chk($sformatf("vec%0d_flag", i), {31'b0, out_flag}, {31'b0, vecs[i].ef});
            chk($sformatf("vec%0d_ovf", i), {31'b0, out_overflow}, {31'b0, vecs[i].eo});
        end

        run_multi("shr20", ALU_SHIFT_RIGHT, 1'b0, 32'h80000000, 1'b1, 32'd20, 32'hFFFFF800, 1'b0, 4);
        run_multi("shl31", ALU_SHIFT_LEFT,  1'b0, 32'h00000001, 1'b0, 32'd31, 32'h80000000, 1'b0, 5);
        run_multi("shl8",  ALU_SHIFT_LEFT,  1'b0, 32'h0000FFFF, 1'b0, 32'd8,  32'h00FFFF00, 1'b0, 2);
        run_multi("shr31", ALU_SHIFT_RIGHT, 1'b0, 32'h80000000, 1'b0, 32'd31, 32'h00000001, 1'b0, 5);
        run_multi("shr1",  ALU_SHIFT_RIGHT, 1'b0, 32'hFFFFFFFF, 1'b0, 32'd1,  32'h7FFFFFFF, 1'b0, 2);
        run_multi("shl0",  ALU_SHIFT_LEFT,  1'b0, 32'hA5A5A5A5, 1'b0, 32'd0,  32'hA5A5A5A5, 1'b0, 1);

        // Backpressure: result must hold and no new op may be taken
        @(negedge clk);
        out_ready = 1'b0;
        drive(ALU_MODE_ADD, ALU_ADD_ADD, ALU_LOGIC_AND, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 drive(ALU_MODE_LOGIC, ALU_ADD_ADD, ALU_LOGIC_OR, 1'b0, 1'b0, 1'b0, 32'h0F, 32'hF0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_d", k), out_d, 32'h80000000);
            chk($sformatf("bp%0d_ready", k), {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_drain_valid", {31'b0, out_valid}, 32'd0);

        // Back-to-back single-cycle ops at full rate
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_ready", k), {31'b0, in_ready}, 32'd1);
            drive(ALU_MODE_ADD, ALU_ADD_ADD, ALU_LOGIC_AND, 1'b0, 1'b0, 1'b0, k, 32'd100, 1'b0, 1'b0, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d_d", k), out_d, 32'd100 + k);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("b2b_end_valid", {31'b0, out_valid}, 32'd0);

        // Reset during an iterative shift discards the op
        @(negedge clk);
        drive(ALU_MODE_SHIFT, ALU_ADD_ADD, ALU_LOGIC_AND, 1'b0, ALU_SHIFT_RIGHT, 1'b0, 32'h80000000, 32'd20, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
        chk("rstmid_ready", {31'b0, in_ready}, 32'd1);
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("rstmid_no_result", seen, 32'd0);
        end

`ifdef DLSC_CPU1_ALU_MUL_EN
        run_multi("mul_big", ALU_SHIFT_LEFT, 1'b1, 32'h00010000, 1'b0, 32'h00010000, 32'h0, 1'b1, 33);
        run_multi("mul_3x5", ALU_SHIFT_LEFT, 1'b1, 32'd3, 1'b0, 32'd5, 32'd15, 1'b0, 33);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
